double_subtractor: RTL

DOUBLE_SUBTRACTOR -- requirements
Module: double_subtractor

---
 rtl/fp64_pkg.sv | 28 ++
 rtl/fp64_unpack.sv | 19 +
 rtl/double_subtractor.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fp64_pkg.sv
// rtl/fp64_pkg.sv - shared constants, FSM encoding and packing helper for the fp64 subtractor
package fp64_pkg;

    localparam int EXP_W   = 11;
    localparam int FRAC_W  = 52;
    localparam int GUARD_W = 3;
    localparam int BIAS    = 1023;
    // hidden one + fraction + guard bits
    localparam int MANT_W  = 1 + FRAC_W + GUARD_W;

    localparam logic [EXP_W-1:0] EXP_MAX = 11'd2047;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_OPER  = 3'd2;
    localparam logic [2:0] ST_NORM  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Assemble a double from sign, biased exponent and the truncated fraction.
    function automatic logic [63:0] pack_fp64(
        input logic              s,
        input logic [EXP_W-1:0]  e,
        input logic [FRAC_W-1:0] f
    );
        return {s, e, f};
    endfunction

endpackage

// File: rtl/fp64_unpack.sv
// rtl/fp64_unpack.sv - splits a double into sign, exponent and guarded mantissa
module fp64_unpack
    import fp64_pkg::*;
(
    input  logic [63:0]        value,
    input  logic               negate,
    output logic               sign,
    output logic [EXP_W-1:0]   exponent,
    output logic [MANT_W-1:0]  mantissa,
    output logic               zero
);

    // Exponent field 0 covers both true zero and denormals, which are flushed.
    assign zero     = (value[62:52] == '0);
    assign sign     = value[63] ^ negate;
    assign exponent = value[62:52];
    assign mantissa = zero ? '0 : {1'b1, value[51:0], 3'b000};

endmodule

// File: rtl/double_subtractor.sv
// rtl/double_subtractor.sv - multi-cycle IEEE-754 double subtractor with valid/ready handshake
module double_subtractor
    import fp64_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] srcA,
    input  logic [63:0] srcB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result
);

    logic               sign_a, sign_b, zero_a, zero_b;
    logic [EXP_W-1:0]   exp_a, exp_b;
    logic [MANT_W-1:0]  mant_a, mant_b;

    fp64_unpack u_unpack_a (
        .value    (srcA),
        .negate   (1'b0),
        .sign     (sign_a),
        .exponent (exp_a),
        .mantissa (mant_a),
        .zero     (zero_a)
    );

    // B is the subtrahend, so its effective sign is flipped and the op becomes an add.
    fp64_unpack u_unpack_b (
        .value    (srcB),
        .negate   (1'b1),
        .sign     (sign_b),
        .exponent (exp_b),
        .mantissa (mant_b),
        .zero     (zero_b)
    );

    logic [2:0]         state;
    logic               sign_r;
    logic               sub_r;
    logic [EXP_W-1:0]   exp_r;
    logic [EXP_W-1:0]   diff_r;
    logic [MANT_W-1:0]  mant_max;
    logic [MANT_W-1:0]  mant_min;
    logic [MANT_W:0]    sum_r;
    logic [63:0]        result_r;

    logic               a_is_max;
    logic [MANT_W:0]    oper_sum;
    logic [MANT_W:0]    norm_mant;
    logic [EXP_W-1:0]   norm_exp;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = result_r;

    // Magnitude ordering: A wins ties so equal magnitudes keep A's sign.
    always_comb begin
        a_is_max = zero_b || (!zero_a && ({exp_a, mant_a} >= {exp_b, mant_b}));
    end

    // Add or subtract the aligned mantissas with one carry bit of headroom.
    always_comb begin
        if (sub_r) begin
            oper_sum = {1'b0, mant_max} - {1'b0, mant_min};
        end else begin
            oper_sum = {1'b0, mant_max} + {1'b0, mant_min};
        end
    end

    // One normalisation step: right on carry, otherwise left.
    always_comb begin
        if (sum_r[MANT_W]) begin
            norm_mant = sum_r >> 1;
            norm_exp  = exp_r + 11'd1;
        end else begin
            norm_mant = sum_r << 1;
            norm_exp  = exp_r - 11'd1;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            sign_r   <= 1'b0;
            sub_r    <= 1'b0;
            exp_r    <= '0;
            diff_r   <= '0;
            mant_max <= '0;
            mant_min <= '0;
            sum_r    <= '0;
            result_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sub_r <= (sign_a != sign_b);
                        if (a_is_max) begin
                            sign_r   <= sign_a;
                            exp_r    <= exp_a;
                            diff_r   <= exp_a - exp_b;
                            mant_max <= mant_a;
                            mant_min <= mant_b;
                        end else begin
                            sign_r   <= sign_b;
                            exp_r    <= exp_b;
                            diff_r   <= exp_b - exp_a;
                            mant_max <= mant_b;
                            mant_min <= mant_a;
                        end
                        state <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (diff_r == '0) begin
                        state <= ST_OPER;
                    end else if (diff_r > 11'd55) begin
                        // Shifted entirely past the guard bits.
                        mant_min <= '0;
                        diff_r   <= '0;
                    end else begin
                        mant_min <= mant_min >> 1;
                        diff_r   <= diff_r - 11'd1;
                    end
                end
                ST_OPER: begin
                    sum_r <= oper_sum;
                    if (oper_sum == '0) begin
                        result_r <= '0;
                        state    <= ST_DONE;
                    end else if (oper_sum[MANT_W] || !oper_sum[MANT_W-1]) begin
                        state <= ST_NORM;
                    end else begin
                        result_r <= pack_fp64(sign_r, exp_r, oper_sum[FRAC_W+GUARD_W-1:GUARD_W]);
                        state    <= ST_DONE;
                    end
                end
                ST_NORM: begin
                    sum_r <= norm_mant;
                    exp_r <= norm_exp;
                    if (sum_r[MANT_W]) begin
                        if (norm_exp == EXP_MAX) begin
                            result_r <= pack_fp64(sign_r, EXP_MAX, '0);
                        end else begin
                            result_r <= pack_fp64(sign_r, norm_exp, norm_mant[FRAC_W+GUARD_W-1:GUARD_W]);
                        end
                        state <= ST_DONE;
                    end else if (norm_exp == '0) begin
                        result_r <= {sign_r, 63'd0};
                        state    <= ST_DONE;
                    end else if (norm_mant[MANT_W-1]) begin
                        result_r <= pack_fp64(sign_r, norm_exp, norm_mant[FRAC_W+GUARD_W-1:GUARD_W]);
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
